rtc_snapshot_bank: RTL and testbench
====================================

# rtc_snapshot_bank

Captures a burst of RTC fields delivered one per clock on `datoRTC` after a start strobe, into a shadow register bank. Commits the bank atomically to an active bank only on a frame boundary, so the VGA text renderer never shows a half-updated time. The renderer reads fields by index. This block is the parametrised successor to the fixed 8-field RTC load path inside the display interface, and sits between the RTC controller and the character/font generator.

## Interface
Parameters:
- `NUM_FIELDS`, default 8: number of fields per burst (seconds, minutes, hours, date, month, year, day, week).
- `DATA_W`, default 8: width of each field.
- `SKIP_CYCLES`, default 0: dead cycles between the detected start and field 0.
- `IDX_W`, default `$clog2(NUM_FIELDS)`: index width (derived; minimum 1).

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `inicioSecuencia` in 1: start request; level input, only its rising edge is used.
- `datoRTC` in `DATA_W`: field data, one field per cycle during capture.
- `frame_tick` in 1: one-cycle pulse at frame start (from the VGA sync generator).
- `rd_idx` in `IDX_W`: field index requested by the renderer.
- `rd_data` out `DATA_W`: registered `active[rd_idx]`.
- `capture_busy` out 1: high while in SKIP or CAPTURE.
- `commit_pulse` out 1: one-cycle pulse on the cycle the active bank is updated.
- `snapshot_valid` out 1: high after the first commit since reset.
- `overrun` out 1: sticky flag; a start was dropped or a pending snapshot was discarded. Cleared on the next commit.

## Operation
- Start edge: `inicioSecuencia`=1 sampled with the previous sample =0. `start_prev` resets to 0.
- FSM states: IDLE, SKIP, CAPTURE, PENDING.
  - IDLE, start edge: go to SKIP, or straight to CAPTURE if `SKIP_CYCLES`=0. `cnt`=0.
  - SKIP: hold for exactly `SKIP_CYCLES` cycles, then go to CAPTURE.
  - CAPTURE: each cycle `shadow[cnt]` <= `datoRTC` and `cnt`++. After writing `cnt`=`NUM_FIELDS`-1, go to PENDING.
  - PENDING, `frame_tick`: `active` <= `shadow` (all fields in one cycle), `commit_pulse`=1, `snapshot_valid`=1, `overrun`=0, go to IDLE.
- Boundary rules:
  - A start edge in SKIP or CAPTURE is ignored and sets `overrun`. The capture in progress is unaffected.
  - A start edge in PENDING without `frame_tick` discards the pending snapshot, restarts capture (to SKIP or CAPTURE, `cnt`=0) and sets `overrun`.
  - A start edge and `frame_tick` in the same PENDING cycle: the commit happens first, then the capture restarts. `overrun` is not set.
  - `frame_tick` in IDLE, SKIP or CAPTURE has no effect. `frame_tick` on the cycle of the last CAPTURE write is not a commit; the next `frame_tick` commits.
  - `rd_idx` >= `NUM_FIELDS` returns 0.
- Reset: asserted at any time (including mid-capture) returns the FSM to IDLE and clears `shadow`, `active` and `cnt`. All outputs are 0 while reset is asserted and after release.

## Timing
- Start edge sampled at edge k. Field i is sampled at edge k+1+`SKIP_CYCLES`+i.
- `capture_busy` is high from k+1 through the edge after the last field write. It is low in PENDING.
- The commit takes 1 cycle from a `frame_tick` sampled in PENDING. `commit_pulse` is high for the following cycle.
- `rd_data` has 1-cycle latency from `rd_idx`.
  - A read sampled on the commit edge returns the old value.
  - A read sampled on the next edge returns the new value.
- Minimum burst period without overrun is `NUM_FIELDS`+`SKIP_CYCLES`+1 cycles, plus the wait for `frame_tick`.

## Structure
- Package `rtc_snapshot_pkg` holds:
  - the FSM state enum;
  - field index constants `F_SEG`=0, `F_MIN`=1, `F_HORA`=2, `F_FECHA`=3, `F_MES`=4, `F_ANIO`=5, `F_DIA`=6, `F_SEMANA`=7.
- One sub-module, `rtc_field_regfile`, holds `shadow` and `active`. It provides:
  - a shadow write port;
  - a bulk copy enable;
  - a registered read port.
- The FSM, edge detect and flags stay in the top level.

## Test plan
- Defaults; start edge, then `datoRTC`=24,4,3,23,12,17,5,4 on consecutive cycles; `frame_tick` 20 cycles later -> `commit_pulse` 1 cycle; reading idx 0..7 returns 24,4,3,23,12,17,5,4; `snapshot_valid`=1; `overrun`=0.
- Capture completes and no `frame_tick` arrives; sweep `rd_idx` -> `rd_data`=0 throughout; a later `frame_tick` commits.
- Second start edge at field 3 of the burst -> burst completes unchanged; `overrun`=1 until the next commit, then 0.
- Start edge in PENDING with new data 59,59,23,31,12,99,7,52, then `frame_tick` -> only the new data is visible; `overrun` cleared by that commit.
- `SKIP_CYCLES`=2, `NUM_FIELDS`=4, `DATA_W`=6; start edge at edge k -> field 0 sampled at k+3; `frame_tick` on the last write edge does not commit.
- `reset` asserted low at field 5 of a burst that follows a committed snapshot -> `rd_data`=0 for all indices, `snapshot_valid`=0, FSM in IDLE; the next burst works normally.

Source files
------------

// File: rtl/rtc_snapshot_pkg.sv
// Shared types and constants for the RTC snapshot bank: FSM state encoding
// and the canonical field order of an RTC burst.
package rtc_snapshot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_PENDING = 2'd3
  } state_e;

  localparam int F_SEG    = 0;
  localparam int F_MIN    = 1;
  localparam int F_HORA   = 2;
  localparam int F_FECHA  = 3;
  localparam int F_MES    = 4;
  localparam int F_ANIO   = 5;
  localparam int F_DIA    = 6;
  localparam int F_SEMANA = 7;

endpackage

// File: rtl/rtc_field_regfile.sv
// Shadow/active field banks: per-field shadow writes, one-cycle bulk copy of
// shadow into active, and a registered read of the active bank.
module rtc_field_regfile #(
  parameter int NUM_FIELDS = 8,
  parameter int DATA_W     = 8,
  parameter int IDX_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              copy_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] shadow_q [NUM_FIELDS];
  logic [DATA_W-1:0] active_q [NUM_FIELDS];
  logic [DATA_W-1:0] rd_data_q;

  // The read samples active before a same-edge copy lands, so a read on the
  // commit edge still returns the previous snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en) shadow_q[wr_idx] <= wr_data;
      if (copy_en) begin
        for (int i = 0; i < NUM_FIELDS; i++) active_q[i] <= shadow_q[i];
      end
      rd_data_q <= (int'(rd_idx) < NUM_FIELDS) ? active_q[rd_idx] : '0;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rtc_snapshot_bank.sv
// Captures an RTC field burst into a shadow bank and commits it to the
// renderer-visible active bank only on a frame boundary.
module rtc_snapshot_bank
  import rtc_snapshot_pkg::*;
#(
  parameter int NUM_FIELDS  = 8,
  parameter int DATA_W      = 8,
  parameter int SKIP_CYCLES = 0,
  parameter int IDX_W       = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inicioSecuencia,
  input  logic [DATA_W-1:0] datoRTC,
  input  logic              frame_tick,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              capture_busy,
  output logic              commit_pulse,
  output logic              snapshot_valid,
  output logic              overrun,
  output state_e            dbg_state
);

  localparam int     SKIP_W     = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;
  localparam state_e RESTART_ST = (SKIP_CYCLES == 0) ? ST_CAPTURE : ST_SKIP;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              start_prev_q;
  logic              commit_q, commit_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              start_edge;
  logic              wr_en;
  logic              copy_en;

  assign start_edge = inicioSecuencia & ~start_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      skip_q       <= '0;
      start_prev_q <= 1'b0;
      commit_q     <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      skip_q       <= skip_d;
      start_prev_q <= inicioSecuencia;
      commit_q     <= commit_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    commit_d  = 1'b0;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    wr_en     = 1'b0;
    copy_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = RESTART_ST;
          cnt_d   = '0;
          skip_d  = '0;
        end
      end
      ST_SKIP: begin
        if (start_edge) overrun_d = 1'b1;
        if (int'(skip_q) == SKIP_CYCLES - 1) state_d = ST_CAPTURE;
        else skip_d = skip_q + 1'b1;
      end
      ST_CAPTURE: begin
        if (start_edge) overrun_d = 1'b1;
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (int'(cnt_q) == NUM_FIELDS - 1) begin
          state_d = ST_PENDING;
          cnt_d   = '0;
        end
      end
      ST_PENDING: begin
        // A simultaneous start commits the finished burst before restarting,
        // so nothing is lost and no overrun is flagged.
        if (frame_tick) begin
          copy_en   = 1'b1;
          commit_d  = 1'b1;
          valid_d   = 1'b1;
          overrun_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (start_edge) begin
          overrun_d = 1'b1;
        end
        if (start_edge) begin
          state_d = RESTART_ST;
          cnt_d   = '0;
          skip_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  rtc_field_regfile #(
    .NUM_FIELDS(NUM_FIELDS),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (reset),
    .wr_en  (wr_en),
    .wr_idx (cnt_q),
    .wr_data(datoRTC),
    .copy_en(copy_en),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

  assign capture_busy   = (state_q == ST_SKIP) || (state_q == ST_CAPTURE);
  assign commit_pulse   = commit_q;
  assign snapshot_valid = valid_q;
  assign overrun        = overrun_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_rtc_snapshot_bank.sv
// Self-checking bench for rtc_snapshot_bank: default configuration against a
// timeline-based reference model, plus small-parameter corner-case instances.
module tb_rtc_snapshot_bank;
  import rtc_snapshot_pkg::*;

  localparam int A_N = 8;
  localparam int A_S = 0;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] exp;
  } rd_vec_t;

  logic clk;
  logic rst_a, rst_bc;

  logic       s_a, ft_a, busy_a, commit_a, valid_a, ovr_a;
  logic [7:0] d_a, rd_a;
  logic [2:0] idx_a;
  state_e     st_a;

  logic       s_b, ft_b, busy_b, commit_b, valid_b, ovr_b;
  logic [5:0] d_b, rd_b;
  logic [1:0] idx_b;
  state_e     st_b;

  logic       s_c, ft_c, busy_c, commit_c, valid_c, ovr_c;
  logic [7:0] d_c, rd_c;
  logic [2:0] idx_c;
  state_e     st_c;

  int checks = 0;
  int failures = 0;

  logic [7:0] t1_data [8];
  logic [7:0] t4_data [8];
  rd_vec_t    t1_tab [8];
  rd_vec_t    c_tab [8];

  // Reference model: capture timing derived from the accepted start cycle.
  logic [7:0] m_shadow [A_N];
  logic [7:0] m_active [A_N];
  logic [7:0] m_rd;
  int         m_t0, m_cyc;
  bit         m_pending, m_valid, m_ovr, m_commit, m_prev;

  rtc_snapshot_bank #(.NUM_FIELDS(8), .DATA_W(8), .SKIP_CYCLES(0)) u_a (
    .clk(clk), .reset(rst_a), .inicioSecuencia(s_a), .datoRTC(d_a),
    .frame_tick(ft_a), .rd_idx(idx_a), .rd_data(rd_a), .capture_busy(busy_a),
    .commit_pulse(commit_a), .snapshot_valid(valid_a), .overrun(ovr_a),
    .dbg_state(st_a)
  );

  rtc_snapshot_bank #(.NUM_FIELDS(4), .DATA_W(6), .SKIP_CYCLES(2)) u_b (
    .clk(clk), .reset(rst_bc), .inicioSecuencia(s_b), .datoRTC(d_b),
    .frame_tick(ft_b), .rd_idx(idx_b), .rd_data(rd_b), .capture_busy(busy_b),
    .commit_pulse(commit_b), .snapshot_valid(valid_b), .overrun(ovr_b),
    .dbg_state(st_b)
  );

  rtc_snapshot_bank #(.NUM_FIELDS(5), .DATA_W(8), .SKIP_CYCLES(0)) u_c (
    .clk(clk), .reset(rst_bc), .inicioSecuencia(s_c), .datoRTC(d_c),
    .frame_tick(ft_c), .rd_idx(idx_c), .rd_data(rd_c), .capture_busy(busy_c),
    .commit_pulse(commit_c), .snapshot_valid(valid_c), .overrun(ovr_c),
    .dbg_state(st_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < A_N; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_rd = '0;
    m_t0 = -1;
    m_cyc = 0;
    m_pending = 0;
    m_valid = 0;
    m_ovr = 0;
    m_commit = 0;
    m_prev = 0;
  endtask

  task automatic model_step(input bit s, input logic [7:0] d, input bit ft, input logic [2:0] idx);
    bit st_edge;
    int fi;
    st_edge = s && !m_prev;
    m_prev = s;
    m_rd = (int'(idx) < A_N) ? m_active[idx] : 8'd0;
    m_commit = 0;
    if (m_pending) begin
      if (ft) begin
        m_active = m_shadow;
        m_commit = 1;
        m_valid = 1;
        m_ovr = 0;
        m_pending = 0;
      end
      if (st_edge) begin
        if (!ft) m_ovr = 1;
        m_pending = 0;
        m_t0 = m_cyc;
      end
    end else if (m_t0 >= 0) begin
      if (st_edge) m_ovr = 1;
      fi = m_cyc - m_t0 - 1 - A_S;
      if (fi >= 0 && fi < A_N) m_shadow[fi] = d;
      if (fi == A_N - 1) begin
        m_pending = 1;
        m_t0 = -1;
      end
    end else if (st_edge) begin
      m_t0 = m_cyc;
    end
    m_cyc++;
  endtask

  task automatic check_a();
    chk("a_rd_data", 32'(rd_a), 32'(m_rd));
    chk("a_capture_busy", 32'(busy_a), 32'(m_t0 >= 0));
    chk("a_commit_pulse", 32'(commit_a), 32'(m_commit));
    chk("a_snapshot_valid", 32'(valid_a), 32'(m_valid));
    chk("a_overrun", 32'(ovr_a), 32'(m_ovr));
  endtask

  task automatic tick_a(input bit s, input logic [7:0] d, input bit ft, input logic [2:0] idx);
    @(negedge clk);
    s_a = s; d_a = d; ft_a = ft; idx_a = idx;
    @(posedge clk);
    model_step(s, d, ft, idx);
    #1;
    check_a();
  endtask

  task automatic reset_a();
    @(negedge clk);
    s_a = 0; d_a = 0; ft_a = 0; idx_a = 0;
    rst_a = 0;
    model_reset();
    #1;
    check_a();
    chk("a_reset_state", 32'(st_a), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_a = 1;
  endtask

  task automatic burst_a(input logic [7:0] base);
    tick_a(1, 0, 0, 0);
    for (int i = 0; i < A_N; i++) tick_a(0, 8'(base + 8'(i)), 0, 0);
  endtask

  initial begin
    t1_data = '{8'd24, 8'd4, 8'd3, 8'd23, 8'd12, 8'd17, 8'd5, 8'd4};
    t4_data = '{8'd59, 8'd59, 8'd23, 8'd31, 8'd12, 8'd99, 8'd7, 8'd52};
    for (int i = 0; i < 8; i++) begin
      t1_tab[i].idx = 3'(i);
      t1_tab[i].exp = t1_data[i];
      c_tab[i].idx  = 3'(i);
      c_tab[i].exp  = (i < 5) ? 8'(i + 1) : 8'd0;
    end

    s_a = 0; d_a = 0; ft_a = 0; idx_a = 0;
    s_b = 0; d_b = 0; ft_b = 0; idx_b = 0;
    s_c = 0; d_c = 0; ft_c = 0; idx_c = 0;
    rst_a = 0; rst_bc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_a();
    chk("a_reset_state", 32'(st_a), 32'(ST_IDLE));
    chk("b_reset_valid", 32'(valid_b), 0);
    chk("b_reset_busy", 32'(busy_b), 0);
    @(negedge clk);
    rst_a = 1; rst_bc = 1;

    // Completed capture without frame_tick stays invisible.
    burst_a(8'd1);
    for (int i = 0; i < 8; i++) begin
      tick_a(0, 0, 0, 3'(i));
      chk("t2_rd_before_commit", 32'(rd_a), 0);
    end
    tick_a(0, 0, 1, 0);
    chk("t2_commit", 32'(commit_a), 1);
    tick_a(0, 0, 0, 2);
    chk("t2_rd_after_commit", 32'(rd_a), 3);

    // Nominal burst, commit 20 cycles later, table-driven readback.
    tick_a(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick_a(0, t1_data[i], 0, 0);
    repeat (19) tick_a(0, 0, 0, 0);
    tick_a(0, 0, 1, 0);
    chk("t1_commit_hi", 32'(commit_a), 1);
    tick_a(0, 0, 0, 0);
    chk("t1_commit_lo", 32'(commit_a), 0);
    for (int i = 0; i < 8; i++) begin
      tick_a(0, 0, 0, t1_tab[i].idx);
      chk("t1_rd", 32'(rd_a), 32'(t1_tab[i].exp));
    end
    chk("t1_valid", 32'(valid_a), 1);
    chk("t1_overrun", 32'(ovr_a), 0);

    // Second start during capture: ignored, sticky overrun until commit.
    tick_a(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick_a(i == 3, 8'(10 + i), 0, 0);
    chk("t3_overrun_set", 32'(ovr_a), 1);
    repeat (5) tick_a(0, 0, 0, 0);
    chk("t3_overrun_hold", 32'(ovr_a), 1);
    tick_a(0, 0, 1, 0);
    chk("t3_overrun_clr", 32'(ovr_a), 0);
    tick_a(0, 0, 0, 3);
    chk("t3_rd3", 32'(rd_a), 13);
    tick_a(0, 0, 0, 7);
    chk("t3_rd7", 32'(rd_a), 17);

    // Start in PENDING discards the pending snapshot.
    burst_a(8'd100);
    repeat (3) tick_a(0, 0, 0, 0);
    tick_a(1, 0, 0, 0);
    chk("t4_overrun", 32'(ovr_a), 1);
    chk("t4_busy", 32'(busy_a), 1);
    for (int i = 0; i < 8; i++) tick_a(0, t4_data[i], 0, 0);
    tick_a(0, 0, 1, 0);
    chk("t4_commit", 32'(commit_a), 1);
    chk("t4_overrun_clr", 32'(ovr_a), 0);
    for (int i = 0; i < 8; i++) begin
      tick_a(0, 0, 0, 3'(i));
      chk("t4_rd", 32'(rd_a), 32'(t4_data[i]));
    end

    // Start and frame_tick together in PENDING: commit, then restart.
    burst_a(8'd30);
    tick_a(1, 0, 1, 0);
    chk("tsame_commit", 32'(commit_a), 1);
    chk("tsame_overrun", 32'(ovr_a), 0);
    chk("tsame_busy", 32'(busy_a), 1);
    for (int i = 0; i < 8; i++) tick_a(0, 8'(40 + i), 0, 0);
    tick_a(0, 0, 1, 5);
    chk("tsame_rd_old", 32'(rd_a), 35);
    tick_a(0, 0, 0, 5);
    chk("tsame_rd_new", 32'(rd_a), 45);

    // Randomized traffic against the model.
    repeat (600) begin
      tick_a($urandom_range(0, 5) == 0, 8'($urandom_range(0, 255)),
             $urandom_range(0, 11) == 0, 3'($urandom_range(0, 7)));
    end

    // Reset in the middle of a burst that follows a committed snapshot.
    repeat (20) tick_a(0, 0, 0, 0);
    tick_a(0, 0, 1, 0);
    burst_a(8'd70);
    tick_a(0, 0, 1, 0);
    tick_a(0, 0, 0, 0);
    chk("trst_valid_before", 32'(valid_a), 1);
    tick_a(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick_a(0, 8'(90 + i), 0, 0);
    reset_a();
    for (int i = 0; i < 8; i++) begin
      tick_a(0, 0, 0, 3'(i));
      chk("trst_rd_zero", 32'(rd_a), 0);
    end
    chk("trst_valid", 32'(valid_a), 0);
    tick_a(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick_a(0, t1_data[i], 0, 0);
    tick_a(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      tick_a(0, 0, 0, t1_tab[i].idx);
      chk("trst_rd_after", 32'(rd_a), 32'(t1_tab[i].exp));
    end

    // SKIP_CYCLES=2, NUM_FIELDS=4, DATA_W=6: d_b carries 10+j at edge k+j.
    @(negedge clk);
    s_b = 1;
    @(posedge clk); #1;
    chk("b_busy_start", 32'(busy_b), 1);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      s_b = 0; d_b = 6'(10 + j); ft_b = (j == 6);
      @(posedge clk); #1;
      if (j == 6) begin
        chk("b_last_write_no_commit", 32'(commit_b), 0);
        chk("b_busy_end", 32'(busy_b), 0);
      end else begin
        chk("b_busy", 32'(busy_b), 1);
      end
    end
    @(negedge clk);
    ft_b = 1; idx_b = 0;
    @(posedge clk); #1;
    chk("b_commit", 32'(commit_b), 1);
    chk("b_rd_old", 32'(rd_b), 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      ft_b = 0; idx_b = 2'(j);
      @(posedge clk); #1;
      chk("b_rd", 32'(rd_b), 32'(13 + j));
    end
    chk("b_valid", 32'(valid_b), 1);
    chk("b_overrun", 32'(ovr_b), 0);

    // NUM_FIELDS=5: indices past the last field read as zero.
    @(negedge clk);
    s_c = 1;
    @(posedge clk);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      s_c = 0; d_c = 8'(j + 1);
      @(posedge clk);
    end
    @(negedge clk);
    ft_c = 1;
    @(posedge clk); #1;
    chk("c_commit", 32'(commit_c), 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ft_c = 0; idx_c = c_tab[i].idx;
      @(posedge clk); #1;
      chk("c_rd", 32'(rd_c), 32'(c_tab[i].exp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
